// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host Wishbone front end: address map, status word layout, FSM states.
package sd_host_pkg;

    localparam logic [4:0] ADR_CMD_EXEC  = 5'd16;
    localparam logic [4:0] ADR_FIFO_WR   = 5'd17;
    localparam logic [4:0] ADR_FIFO_RD   = 5'd18;
    localparam logic [4:0] ADR_DATA_EXEC = 5'd19;

    localparam int ST_CMD_BUSY   = 0;
    localparam int ST_DATA_BUSY  = 1;
    localparam int ST_TX_FULL    = 2;
    localparam int ST_TX_EMPTY   = 3;
    localparam int ST_RX_FULL    = 4;
    localparam int ST_RX_EMPTY   = 5;
    localparam int ST_RX_OVF     = 6;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_RESP = 1'b1
    } wb_state_e;

    // Addresses 0-15 map straight onto the register file.
    function automatic logic is_reg_adr(input logic [4:0] adr);
        return !adr[4];
    endfunction

endpackage

// File: rtl/sd_wb_slave_if.sv
// Wishbone request/response bundle between the bench master and the SD host slave.
interface sd_wb_slave_if #(
    parameter int DATA_W = 128
) ();
    logic              strobe_i;
    logic              we_i;
    logic [4:0]        adr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              ack_o;
    logic              error_o;

    modport master (
        output strobe_i, we_i, adr_i, wb_data_i,
        input  wb_data_o, ack_o, error_o
    );

    modport slave (
        input  strobe_i, we_i, adr_i, wb_data_i,
        output wb_data_o, ack_o, error_o
    );
endinterface

// File: rtl/sd_fifo.sv
// Show-ahead FIFO with occupancy count; head is 0 while empty, push-when-full and pop-when-empty are ignored.
// Push/pop take effect at the clock edge; full/empty reflect pre-edge occupancy.
module sd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so they wrap for power-of-two depths.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/sd_wb_slave.sv
// Wishbone slave for the SD host: register file, cmd/data exec triggers, TX/RX FIFOs; one ack/error 1 cycle after strobe,
// one access per 2 cycles. SD_WB_ERR_RESP_EN enables error_o; otherwise illegal accesses are acked and have no effect.
module sd_wb_slave
    import sd_host_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 128,
    parameter int REG_W      = 32
) (
    input  logic              wb_clock,
    input  logic              reset,
    sd_wb_slave_if.slave      wb,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              cmd_done_i,
    input  logic              data_done_i,
    output logic              cmd_start_o,
    output logic              data_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_empty_o,
    input  logic              tx_pop_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_state_e         state_q, state_d;
    logic              ack_q, ack_d;
`ifdef SD_WB_ERR_RESP_EN
    logic              err_q, err_d;
`endif
    logic              cmd_start_q, cmd_start_d;
    logic              data_start_q, data_start_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [REG_W-1:0]  regs_q [16];
    logic [REG_W-1:0]  regs_d [16];
    logic              cmd_busy_q, cmd_busy_d;
    logic              data_busy_q, data_busy_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              done_prev_q;

    logic              illegal;
    logic              tx_push, rx_pop, rx_push;
    logic              tx_full, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic [DATA_W-1:0] status;

    assign rx_push = data_done_i && !done_prev_q;

    sd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk        (wb_clock),
        .rst        (reset),
        .push_i     (tx_push),
        .push_dat_i (wb.wb_data_i),
        .pop_i      (tx_pop_i),
        .head_o     (tx_data_o),
        .count_o    (tx_count),
        .full_o     (tx_full),
        .empty_o    (tx_empty_o)
    );

    sd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk        (wb_clock),
        .rst        (reset),
        .push_i     (rx_push),
        .push_dat_i (host_data_i),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .count_o    (rx_count),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    always_comb begin
        status                        = '0;
        status[ST_CMD_BUSY]           = cmd_busy_q;
        status[ST_DATA_BUSY]          = data_busy_q;
        status[ST_TX_FULL]            = tx_full;
        status[ST_TX_EMPTY]           = tx_empty_o;
        status[ST_RX_FULL]            = rx_full;
        status[ST_RX_EMPTY]           = rx_empty;
        status[ST_RX_OVF]             = rx_ovf_q;
        status[ST_TX_CNT_LSB +: 8]    = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]    = 8'(rx_count);
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
`ifdef SD_WB_ERR_RESP_EN
        err_d        = 1'b0;
`endif
        cmd_start_d  = 1'b0;
        data_start_d = 1'b0;
        rdata_d      = rdata_q;
        regs_d       = regs_q;
        illegal      = 1'b0;
        tx_push      = 1'b0;
        rx_pop       = 1'b0;
        rx_ovf_d     = rx_ovf_q;
        cmd_busy_d   = (cmd_busy_q && cmd_done_i) ? 1'b0 : cmd_busy_q;
        data_busy_d  = (data_busy_q && data_done_i) ? 1'b0 : data_busy_q;

        case (state_q)
            WB_IDLE: begin
                if (wb.strobe_i) begin
                    state_d = WB_RESP;
                    if (is_reg_adr(wb.adr_i)) begin
                        if (wb.we_i) regs_d[wb.adr_i[3:0]] = wb.wb_data_i[REG_W-1:0];
                        else         rdata_d = DATA_W'(regs_q[wb.adr_i[3:0]]);
                    end else begin
                        case (wb.adr_i)
                            ADR_CMD_EXEC, ADR_DATA_EXEC: begin
                                if (!wb.we_i) begin
                                    rdata_d  = status;
                                    rx_ovf_d = 1'b0;
                                end else if (wb.adr_i == ADR_CMD_EXEC) begin
                                    // Busy is judged on the pre-edge value; a same-cycle done does not help.
                                    if (cmd_busy_q) illegal = 1'b1;
                                    else begin
                                        cmd_busy_d  = 1'b1;
                                        cmd_start_d = 1'b1;
                                    end
                                end else begin
                                    if (data_busy_q) illegal = 1'b1;
                                    else begin
                                        data_busy_d  = 1'b1;
                                        data_start_d = 1'b1;
                                    end
                                end
                            end
                            ADR_FIFO_WR: begin
                                if (wb.we_i && !tx_full) tx_push = 1'b1;
                                else                     illegal = 1'b1;
                            end
                            ADR_FIFO_RD: begin
                                if (!wb.we_i && !rx_empty) begin
                                    rdata_d = rx_head;
                                    rx_pop  = 1'b1;
                                end else begin
                                    illegal = 1'b1;
                                end
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
`ifdef SD_WB_ERR_RESP_EN
                    err_d = illegal;
                    ack_d = !illegal;
`else
                    ack_d = 1'b1;
                    if (illegal && !wb.we_i) rdata_d = '0;
`endif
                end
            end
            WB_RESP: state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase

        // A drop on a full RX FIFO wins over a same-cycle status-read clear.
        if (rx_push && rx_full) rx_ovf_d = 1'b1;
    end

    always_ff @(posedge wb_clock) begin
        if (reset) begin
            state_q      <= WB_IDLE;
            ack_q        <= 1'b0;
`ifdef SD_WB_ERR_RESP_EN
            err_q        <= 1'b0;
`endif
            cmd_start_q  <= 1'b0;
            data_start_q <= 1'b0;
            rdata_q      <= '0;
            regs_q       <= '{default: '0};
            cmd_busy_q   <= 1'b0;
            data_busy_q  <= 1'b0;
            rx_ovf_q     <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
`ifdef SD_WB_ERR_RESP_EN
            err_q        <= err_d;
`endif
            cmd_start_q  <= cmd_start_d;
            data_start_q <= data_start_d;
            rdata_q      <= rdata_d;
            regs_q       <= regs_d;
            cmd_busy_q   <= cmd_busy_d;
            data_busy_q  <= data_busy_d;
            rx_ovf_q     <= rx_ovf_d;
            done_prev_q  <= data_done_i;
        end
    end

    assign wb.wb_data_o = rdata_q;
    assign wb.ack_o     = ack_q;
`ifdef SD_WB_ERR_RESP_EN
    assign wb.error_o   = err_q;
`else
    assign wb.error_o   = 1'b0;
`endif
    assign cmd_start_o  = cmd_start_q;
    assign data_start_o = data_start_q;

endmodule

// File: tb/tb_sd_wb_slave.sv
// Scoreboard bench for sd_wb_slave: directed Wishbone accesses queue expected responses; a negedge monitor checks them.
module tb_sd_wb_slave;
    localparam int DW = 128;
`ifdef SD_WB_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit            err;
        logic [DW-1:0] dat;
        bit            cs;
        bit            ds;
    } exp_t;

    logic          wb_clock = 1'b0;
    logic          reset;
    logic [DW-1:0] host_data_i;
    logic          cmd_done_i, data_done_i, tx_pop_i;
    logic          cmd_start_o, data_start_o, tx_empty_o;
    logic [DW-1:0] tx_data_o;

    exp_t          exp_q [$];
    string         name_q [$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last_rd = '0;

    sd_wb_slave_if #(.DATA_W(DW)) bus ();

    sd_wb_slave #(.FIFO_DEPTH(8), .DATA_W(DW), .REG_W(32)) dut (
        .wb_clock     (wb_clock),
        .reset        (reset),
        .wb           (bus),
        .host_data_i  (host_data_i),
        .cmd_done_i   (cmd_done_i),
        .data_done_i  (data_done_i),
        .cmd_start_o  (cmd_start_o),
        .data_start_o (data_start_o),
        .tx_data_o    (tx_data_o),
        .tx_empty_o   (tx_empty_o),
        .tx_pop_i     (tx_pop_i)
    );

    always #5 wb_clock = ~wb_clock;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack/error cycle must match the oldest queued expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge wb_clock);
            if (bus.ack_o || bus.error_o) begin
                chk("ack_err_exclusive", DW'(bus.ack_o && bus.error_o), '0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_response: got ack=%0b err=%0b expected none", bus.ack_o, bus.error_o);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk({n, "_err"}, DW'(bus.error_o), DW'(e.err));
                    chk({n, "_ack"}, DW'(bus.ack_o), DW'(!e.err));
                    chk({n, "_data"}, bus.wb_data_o, e.dat);
                    chk({n, "_cmd_start"}, DW'(cmd_start_o), DW'(e.cs));
                    chk({n, "_data_start"}, DW'(data_start_o), DW'(e.ds));
                end
            end else if (cmd_start_o || data_start_o) begin
                checks++;
                failures++;
                $display("FAIL stray_start: got cmd=%0b data=%0b expected 0 outside response", cmd_start_o, data_start_o);
            end
        end
    end

    task automatic txn(input string nm, input bit we, input logic [4:0] adr, input logic [DW-1:0] wdat,
                       input bit illegal, input logic [DW-1:0] rexp, input bit cs, input bit ds,
                       input bit pop, input bit rst_resp);
        exp_t e;
        e.err = illegal && ERR_EN;
        if (!we && !illegal)              last_rd = rexp;
        else if (!we && illegal && !ERR_EN) last_rd = '0;
        e.dat = last_rd;
        e.cs  = cs;
        e.ds  = ds;
        @(negedge wb_clock);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.strobe_i  = 1'b1;
        bus.we_i      = we;
        bus.adr_i     = adr;
        bus.wb_data_i = wdat;
        tx_pop_i      = pop;
        @(posedge wb_clock);
        #1;
        bus.strobe_i = 1'b0;
        tx_pop_i     = 1'b0;
        if (rst_resp) reset = 1'b1;
        @(posedge wb_clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending responses expected 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        if (rst_resp) begin
            chk({nm, "_ack_after_rst"}, DW'(bus.ack_o), '0);
            chk({nm, "_err_after_rst"}, DW'(bus.error_o), '0);
            @(negedge wb_clock);
            reset   = 1'b0;
            last_rd = '0;
        end
    endtask

    task automatic wr(input string nm, input logic [4:0] adr, input logic [DW-1:0] d);
        txn(nm, 1'b1, adr, d, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string nm, input logic [4:0] adr, input logic [DW-1:0] exp);
        txn(nm, 1'b0, adr, '0, 1'b0, exp, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bad(input string nm, input bit we, input logic [4:0] adr);
        txn(nm, we, adr, 128'hBAD, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_tx();
        @(negedge wb_clock);
        tx_pop_i = 1'b1;
        @(posedge wb_clock);
        #1;
        tx_pop_i = 1'b0;
    endtask

    task automatic rx_pulse(input logic [DW-1:0] d);
        @(negedge wb_clock);
        host_data_i = d;
        data_done_i = 1'b1;
        @(negedge wb_clock);
        data_done_i = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.strobe_i  = 1'b0;
        bus.we_i      = 1'b0;
        bus.adr_i     = '0;
        bus.wb_data_i = '0;
        host_data_i   = '0;
        cmd_done_i    = 1'b0;
        data_done_i   = 1'b0;
        tx_pop_i      = 1'b0;
        repeat (3) @(posedge wb_clock);
        #1;
        chk("rst_ack", DW'(bus.ack_o), '0);
        chk("rst_err", DW'(bus.error_o), '0);
        chk("rst_rdata", bus.wb_data_o, '0);
        chk("rst_tx_empty", DW'(tx_empty_o), DW'(1));
        chk("rst_tx_data", tx_data_o, '0);
        chk("rst_starts", DW'({cmd_start_o, data_start_o}), '0);
        @(negedge wb_clock);
        reset = 1'b0;

        wr("reg5_wr", 5'd5, 128'hDEADBEEF);
        rd("reg5_rd", 5'd5, 128'hDEADBEEF);
        wr("reg0_wr", 5'd0, {96'h123456789ABCDEF012345678, 32'hCAFEF00D});
        rd("reg0_rd", 5'd0, 128'hCAFEF00D);
        rd("reg15_rd", 5'd15, '0);
        rd("reg5_rd2", 5'd5, 128'hDEADBEEF);
        rd("status_idle", 5'd16, 128'h28);

        txn("cmd_exec1", 1'b1, 5'd16, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rd("status_cmd_busy", 5'd16, 128'h29);
        txn("cmd_exec_busy", 1'b1, 5'd16, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge wb_clock);
        cmd_done_i = 1'b1;
        @(negedge wb_clock);
        cmd_done_i = 1'b0;
        txn("cmd_exec2", 1'b1, 5'd16, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd_done_i = 1'b1;
        txn("cmd_exec_busy_done", 1'b1, 5'd16, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd_done_i = 1'b0;
        rd("status_cmd_clr", 5'd16, 128'h28);

        txn("data_exec1", 1'b1, 5'd19, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        txn("data_exec_busy", 1'b1, 5'd19, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd("status_adr19", 5'd19, 128'h2A);

        for (int i = 1; i <= 8; i++) wr("tx_push", 5'd17, DW'(5 * i));
        rd("status_tx_full", 5'd16, 128'h0826);
        bad("tx_push_full", 1'b1, 5'd17);
        chk("tx_head_first", tx_data_o, 128'd5);
        bad("tx_fifo_read", 1'b0, 5'd17);
        pop_tx();
        chk("tx_head_after_pop", tx_data_o, 128'd10);
        txn("tx_push_pop", 1'b1, 5'd17, 128'd45, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tx_head_push_pop", tx_data_o, 128'd15);
        wr("tx_push_fill", 5'd17, 128'd50);
        txn("tx_push_full_pop", 1'b1, 5'd17, 128'd55, 1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tx_head_full_pop", tx_data_o, 128'd20);
        rd("status_tx7", 5'd16, 128'h0722);
        for (int k = 0; k < 7; k++) begin
            chk("tx_drain_head", tx_data_o, DW'(20 + 5 * k));
            pop_tx();
        end
        chk("tx_drained_empty", DW'(tx_empty_o), DW'(1));
        chk("tx_drained_data", tx_data_o, '0);
        pop_tx();
        rd("status_tx_pop_empty", 5'd16, 128'h2A);

        for (int k = 1; k <= 9; k++) rx_pulse(DW'(k));
        rd("status_rx_ovf", 5'd16, 128'h080058);
        rd("status_ovf_clr", 5'd16, 128'h080018);
        for (int k = 1; k <= 8; k++) rd("rx_read", 5'd18, DW'(k));
        bad("rx_read_empty", 1'b0, 5'd18);
        bad("rx_write", 1'b1, 5'd18);
        bad("adr25_wr", 1'b1, 5'd25);
        bad("adr25_rd", 1'b0, 5'd25);
        bad("adr20_rd", 1'b0, 5'd20);
        bad("adr31_wr", 1'b1, 5'd31);
        rd("status_after_illegal", 5'd16, 128'h28);

        txn("cmd_exec3", 1'b1, 5'd16, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        wr("tx_push_pre_rst", 5'd17, 128'h77);
        chk("tx_nonempty_pre_rst", DW'(tx_empty_o), '0);
        txn("rd_rst_resp", 1'b0, 5'd5, '0, 1'b0, 128'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rdata_after_rst", bus.wb_data_o, '0);
        chk("tx_empty_after_rst", DW'(tx_empty_o), DW'(1));
        chk("tx_data_after_rst", tx_data_o, '0);
        rd("status_after_rst", 5'd16, 128'h28);
        rd("reg5_after_rst", 5'd5, '0);

        repeat (4) @(posedge wb_clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
